// File: rtl/parity_frame_rx_if.sv
// Word path of the parity frame receiver: serial bit input and the
// valid/ready word output share one bundle.
//   bit_valid/bit_in : qualified serial line bits into the receiver
//   out_valid/out_ready : word handshake out of the receiver
//   out_data, out_par_err, out_frm_err : word payload and its status flags
// The slave modport is the receiver, the master modport is the line
// front-end plus word consumer.
interface parity_frame_rx_if #(
    parameter int N = 8
);
    logic         bit_valid;
    logic         bit_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_par_err;
    logic         out_frm_err;

    modport slave (
        input  bit_valid, bit_in, out_ready,
        output out_valid, out_data, out_par_err, out_frm_err
    );

    modport master (
        output bit_valid, bit_in, out_ready,
        input  out_valid, out_data, out_par_err, out_frm_err
    );
endinterface

// File: rtl/parity_frame_rx.sv
// Receive-side checker for the XOR-parity serial link.
// Frames are {start=0, N data bits LSB-first, parity, stop=1}, one bit per
// cycle with bit_valid=1. Each completed frame is presented on a one-deep
// valid/ready slot together with its parity and framing status.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : serial input and word output (slave side of parity_frame_rx_if,
//               whose N must match this module's N)
//   busy      : receiver is inside a frame
//   overrun   : one-cycle pulse when a completed frame found the slot full
//   err_cnt   : saturating count of parity, framing and overrun events
module parity_frame_rx #(
    parameter int N          = 8,
    parameter int PARITY_ODD = 0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    parity_frame_rx_if.slave bus,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state;
    logic [N-1:0]     shreg;
    logic [IDX_W-1:0] idx;
    logic             par_q;    // parity verdict of the frame in flight

    logic             vld_q;
    logic [N-1:0]     data_q;
    logic             par_err_q;
    logic             frm_err_q;

    logic             slot_free;
    logic [CNT_W-1:0] cnt_inc;

    // The slot can take a new word if empty or draining in this same cycle.
    assign slot_free = !vld_q || bus.out_ready;
    assign cnt_inc   = (err_cnt == {CNT_W{1'b1}}) ? err_cnt : err_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            par_q     <= 1'b0;
            vld_q     <= 1'b0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            overrun   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            overrun <= 1'b0;

            // Acceptance empties the slot; a completion below overrides this.
            if (vld_q && bus.out_ready)
                vld_q <= 1'b0;

            if (bus.bit_valid) begin
                case (state)
                    IDLE: begin
                        if (!bus.bit_in) begin
                            shreg <= '0;
                            idx   <= '0;
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        shreg[idx] <= bus.bit_in;
                        if (idx == IDX_LAST)
                            state <= PARITY;
                        else
                            idx <= idx + 1'b1;
                    end
                    PARITY: begin
                        par_q <= ((^shreg) ^ bus.bit_in) != ODD;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (slot_free) begin
                            vld_q     <= 1'b1;
                            data_q    <= shreg;
                            par_err_q <= par_q;
                            frm_err_q <= !bus.bit_in;
                            if (par_q || !bus.bit_in)
                                err_cnt <= cnt_inc;
                        end else begin
                            // Slot held and not draining: the new frame is lost.
                            overrun <= 1'b1;
                            err_cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy            = (state != IDLE);
    assign bus.out_valid   = vld_q;
    assign bus.out_data    = data_q;
    assign bus.out_par_err = par_err_q;
    assign bus.out_frm_err = frm_err_q;
endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy, overrun, busy2, ovr2;
    logic [7:0] err_cnt, cnt2;

    parity_frame_rx_if #(.N(N)) bus ();
    parity_frame_rx_if #(.N(N)) bus2 ();

    // Second receiver with odd parity listens to the same line, always ready.
    assign bus2.bit_valid = bus.bit_valid;
    assign bus2.bit_in    = bus.bit_in;
    assign bus2.out_ready = 1'b1;

    parity_frame_rx #(.N(N), .PARITY_ODD(0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .overrun(overrun), .err_cnt(err_cnt)
    );

    parity_frame_rx #(.N(N), .PARITY_ODD(1), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .busy(busy2), .overrun(ovr2), .err_cnt(cnt2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: qualified bits are collected into a frame list; a
    // frame is judged once start + N data + parity + stop have arrived.
    logic       mq[$];
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_par, m_frm, m_ovr;
    int         m_cnt;
    logic       chk2;
    logic [7:0] e2_data;
    logic       e2_par;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic bump();
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic step(input logic v, input logic b, input logic r);
        logic       loaded, acc, p, s, pe, fe;
        logic [7:0] d;
        loaded = 1'b0;
        @(negedge clk);
        bus.bit_valid = v;
        bus.bit_in    = b;
        bus.out_ready = r;
        acc   = m_valid && r;
        m_ovr = 1'b0;
        chk2  = 1'b0;
        if (v) begin
            if (mq.size() != 0 || b == 1'b0) mq.push_back(b);
            if (mq.size() == N + 3) begin
                for (int i = 0; i < N; i++) d[i] = mq[i+1];
                p = mq[N+1];
                s = mq[N+2];
                mq.delete();
                pe = (($countones(d) + int'(p)) % 2) != 0;
                fe = !s;
                chk2    = 1'b1;
                e2_data = d;
                e2_par  = (($countones(d) + int'(p)) % 2) != 1;
                if (!m_valid || r) begin
                    m_valid = 1'b1;
                    m_data  = d;
                    m_par   = pe;
                    m_frm   = fe;
                    loaded  = 1'b1;
                    if (pe || fe) bump();
                end else begin
                    m_ovr = 1'b1;
                    bump();
                end
            end
        end
        if (acc && !loaded) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(mq.size() != 0));
        if (m_valid) begin
            chk("out_data", 32'(bus.out_data), 32'(m_data));
            chk("par_err", 32'(bus.out_par_err), 32'(m_par));
            chk("frm_err", 32'(bus.out_frm_err), 32'(m_frm));
        end
        if (chk2) begin
            chk("odd_valid", 32'(bus2.out_valid), 32'd1);
            chk("odd_data", 32'(bus2.out_data), 32'(e2_data));
            chk("odd_par_err", 32'(bus2.out_par_err), 32'(e2_par));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.bit_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        m_valid = 1'b0;
        m_cnt   = 0;
        m_ovr   = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_flags", 32'({bus.out_par_err, bus.out_frm_err, overrun}), 32'd0);
        chk("rst_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // tog inserts a bit_valid=0 cycle (random line value) after every bit
    // except the stop bit; rb is out_ready during the frame, rs at the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input logic tog, input logic rb, input logic rs);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            step(1'b1, bits[i], (i == 10) ? rs : rb);
            if (tog && i != 10) step(1'b0, 1'($urandom), rb);
        end
    endtask

    task automatic drain();
        step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b1;
        bus.out_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_par   = 1'b0;
        m_frm   = 1'b0;
        m_ovr   = 1'b0;
        m_cnt   = 0;
        chk2    = 1'b0;
        do_reset();

        // 1: good frame, contiguous then with gaps
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_data", 32'(bus.out_data), 32'hA5);
        chk("t1_flags", 32'({bus.out_par_err, bus.out_frm_err}), 32'd0);
        chk("t1_cnt", 32'(err_cnt), 32'd0);
        drain();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t1g_data", 32'(bus.out_data), 32'hA5);
        chk("t1g_flags", 32'({bus.out_par_err, bus.out_frm_err}), 32'd0);
        drain();

        // 2: wrong even parity, correct for odd
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_par", 32'(bus.out_par_err), 32'd1);
        chk("t2_frm", 32'(bus.out_frm_err), 32'd0);
        chk("t2_cnt", 32'(err_cnt), 32'd1);
        chk("t2_odd_par", 32'(bus2.out_par_err), 32'd0);
        drain();

        // 3: framing error
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_frm", 32'(bus.out_frm_err), 32'd1);
        chk("t3_par", 32'(bus.out_par_err), 32'd0);
        chk("t3_cnt", 32'(err_cnt), 32'd2);
        drain();

        // 4: overrun, then accept-and-load in the stop cycle
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_ovr", 32'(overrun), 32'd1);
        chk("t4_data", 32'(bus.out_data), 32'h11);
        chk("t4_cnt", 32'(err_cnt), 32'd3);
        step(1'b0, 1'b1, 1'b0);
        chk("t4_ovr_pulse", 32'(overrun), 32'd0);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_data33", 32'(bus.out_data), 32'h33);
        chk("t4_no_ovr", 32'(overrun), 32'd0);
        chk("t4_cnt2", 32'(err_cnt), 32'd3);
        drain();

        // 5: reset mid-frame
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom), 1'b0);
        do_reset();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_data", 32'(bus.out_data), 32'h5A);
        chk("t5_flags", 32'({bus.out_par_err, bus.out_frm_err}), 32'd0);
        drain();

        // 6: idle line, then saturate the counter
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1);
            chk("t6_idle", 32'(bus.out_valid), 32'd0);
        end
        for (int i = 0; i < 260; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send_frame(d, ~(^d), 1'b1, 1'b0, 1'b1, 1'b1);
        end
        chk("t6_sat", 32'(err_cnt), 32'hFF);

        // Random frames with gaps, idle bits, random ready and stop values.
        do_reset();
        for (int f = 0; f < 60; f++) begin
            logic [7:0]  d;
            logic [10:0] bits;
            d    = 8'($urandom);
            bits = {($urandom_range(3) != 0), 1'($urandom), d, 1'b0};
            for (int k = $urandom_range(2); k > 0; k--) step(1'b1, 1'b1, 1'($urandom));
            for (int i = 0; i < 11; i++) begin
                if ($urandom_range(3) == 0) step(1'b0, 1'($urandom), 1'($urandom));
                step(1'b1, bits[i], 1'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
